// File: rtl/conv_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : conv_pkg
//  Purpose  : Shared defaults, FSM state encoding and window-slot helper for
//             the convolution window buffer.
//  Revision : 1.0 - initial release
// ============================================================================
package conv_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_KERNEL = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  // Flat slot index of window element (row r, column c) for a k x k window.
  function automatic int slot_idx(input int r, input int c, input int k);
    return r * k + c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/conv_line_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : conv_line_buffer
//  Purpose  : KERNEL-1 line buffers sharing one column address. A write
//             shifts the column down (row j takes row j-1, row 0 takes din);
//             reads are asynchronous and see the pre-write contents.
//  Revision : 1.0 - initial release
// ============================================================================
module conv_line_buffer #(
  parameter int DATA_W    = 16,
  parameter int KERNEL    = 3,
  parameter int MAX_WIDTH = 1024,
  parameter int ADDR_W    = 10
) (
  input  logic                         clk,
  input  logic                         we,
  input  logic [ADDR_W-1:0]            addr,
  input  logic [DATA_W-1:0]            din,
  output logic [(KERNEL-1)*DATA_W-1:0] rd_col
);

  generate
    for (genvar j = 0; j < KERNEL - 1; j++) begin : g_row
      logic [DATA_W-1:0] mem_q [MAX_WIDTH];

      assign rd_col[j*DATA_W +: DATA_W] = mem_q[addr];

      if (j == 0) begin : g_head
        // Newest line takes the incoming pixel.
        always_ff @(posedge clk) begin
          if (we) mem_q[addr] <= din;
        end
      end else begin : g_tail
        // Older lines take the pre-write value of the line above them.
        always_ff @(posedge clk) begin
          if (we) mem_q[addr] <= rd_col[(j-1)*DATA_W +: DATA_W];
        end
      end
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/conv_window_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : conv_window_buffer
//  Purpose  : Raster-order pixel stream in, every valid KERNEL x KERNEL
//             window out as one flat word. Rows are reused from line buffers
//             so each pixel is streamed once. One-deep output register with
//             backpressure on both sides; tlast mismatch flagged, not acted on.
//  Revision : 1.0 - initial release
// ============================================================================
module conv_window_buffer
  import conv_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int KERNEL    = DEF_KERNEL,
  parameter int MAX_WIDTH = 1024,
  parameter int DIM_W     = 11
) (
  input  logic                              Clk,
  input  logic                              Rst,
  input  logic [DIM_W-1:0]                  cfg_width,
  input  logic [DIM_W-1:0]                  cfg_height,
  input  logic                              cfg_start,
  output logic                              cfg_err,
  input  logic                              s_axis_valid,
  input  logic [DATA_W-1:0]                 s_axis_data,
  output logic                              s_axis_ready,
  input  logic                              s_axis_last,
  output logic                              win_valid,
  output logic [KERNEL*KERNEL*DATA_W-1:0]   win_data,
  input  logic                              win_ready,
  output logic                              win_last,
  output logic                              busy,
  output logic                              done,
  output logic                              err_last
);

  localparam int ADDR_W = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
  localparam int WIN_W  = KERNEL * KERNEL * DATA_W;
  localparam logic [DIM_W-1:0] C_ONE   = DIM_W'(1);
  localparam logic [DIM_W-1:0] C_K     = DIM_W'(KERNEL);
  localparam logic [DIM_W-1:0] C_K_M1  = DIM_W'(KERNEL - 1);
  localparam logic [DIM_W:0]   C_MAX_W = (DIM_W + 1)'(MAX_WIDTH);

  state_t             state_q, state_d;
  logic [DIM_W-1:0]   w_q, w_d, h_q, h_d;
  logic [DIM_W-1:0]   row_q, row_d, col_q, col_d;
  logic [WIN_W-1:0]   win_q, win_d;
  logic               win_valid_q, win_valid_d;
  logic               win_last_q, win_last_d;
  logic               done_q, done_d;
  logic               cfg_err_q, cfg_err_d;
  logic               err_last_q, err_last_d;

  logic                         accept;
  logic                         at_last_pix;
  logic                         in_window;
  logic                         cfg_bad;
  logic [(KERNEL-1)*DATA_W-1:0] lb_col;

  conv_line_buffer #(
    .DATA_W    (DATA_W),
    .KERNEL    (KERNEL),
    .MAX_WIDTH (MAX_WIDTH),
    .ADDR_W    (ADDR_W)
  ) u_line_buffer (
    .clk    (Clk),
    .we     (accept),
    .addr   (col_q[ADDR_W-1:0]),
    .din    (s_axis_data),
    .rd_col (lb_col)
  );

  // Next-state, counters, window shift and handshake decode.
  always_comb begin
    state_d      = state_q;
    w_d          = w_q;
    h_d          = h_q;
    row_d        = row_q;
    col_d        = col_q;
    win_d        = win_q;
    win_valid_d  = win_valid_q;
    win_last_d   = win_last_q;
    done_d       = 1'b0;
    cfg_err_d    = cfg_err_q;
    err_last_d   = err_last_q;
    s_axis_ready = 1'b0;
    accept       = 1'b0;

    // Completion is detected on coordinates; W*H is never formed.
    at_last_pix = (row_q == h_q - C_ONE) && (col_q == w_q - C_ONE);
    in_window   = (row_q >= C_K_M1) && (col_q >= C_K_M1);
    cfg_bad     = (cfg_width < C_K) || (cfg_height < C_K) ||
                  ({1'b0, cfg_width} > C_MAX_W);

    // A held window retires when the consumer takes it; a new load below wins.
    if (win_valid_q && win_ready) begin
      win_valid_d = 1'b0;
      win_last_d  = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (cfg_start) begin
          w_d   = cfg_width;
          h_d   = cfg_height;
          row_d = '0;
          col_d = '0;
          if (cfg_bad) begin
            cfg_err_d = 1'b1;
          end else begin
            cfg_err_d  = 1'b0;
            err_last_d = 1'b0;
            state_d    = ST_RUN;
          end
        end
      end

      ST_RUN: begin
        s_axis_ready = !win_valid_q || win_ready;
        accept       = s_axis_valid && s_axis_ready;
        if (accept) begin
          // Shift every row one column toward c=0.
          for (int r = 0; r < KERNEL; r++) begin
            for (int c = 0; c < KERNEL - 1; c++) begin
              win_d[slot_idx(r, c, KERNEL)*DATA_W +: DATA_W] =
                win_q[slot_idx(r, c + 1, KERNEL)*DATA_W +: DATA_W];
            end
          end
          // New column: oldest line buffer at r=0, live pixel at r=K-1.
          for (int r = 0; r < KERNEL - 1; r++) begin
            win_d[slot_idx(r, KERNEL - 1, KERNEL)*DATA_W +: DATA_W] =
              lb_col[(KERNEL - 2 - r)*DATA_W +: DATA_W];
          end
          win_d[slot_idx(KERNEL - 1, KERNEL - 1, KERNEL)*DATA_W +: DATA_W] = s_axis_data;

          if (in_window) begin
            win_valid_d = 1'b1;
            win_last_d  = at_last_pix;
          end

          if (s_axis_last != at_last_pix) err_last_d = 1'b1;

          if (at_last_pix) begin
            state_d = ST_FLUSH;
          end else if (col_q == w_q - C_ONE) begin
            col_d = '0;
            row_d = row_q + C_ONE;
          end else begin
            col_d = col_q + C_ONE;
          end
        end
      end

      ST_FLUSH: begin
        if (win_valid_q && win_ready && win_last_q) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any frame in flight.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q     <= ST_IDLE;
      w_q         <= '0;
      h_q         <= '0;
      row_q       <= '0;
      col_q       <= '0;
      win_q       <= '0;
      win_valid_q <= 1'b0;
      win_last_q  <= 1'b0;
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
      err_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      w_q         <= w_d;
      h_q         <= h_d;
      row_q       <= row_d;
      col_q       <= col_d;
      win_q       <= win_d;
      win_valid_q <= win_valid_d;
      win_last_q  <= win_last_d;
      done_q      <= done_d;
      cfg_err_q   <= cfg_err_d;
      err_last_q  <= err_last_d;
    end
  end

  assign win_valid = win_valid_q;
  assign win_data  = win_q;
  assign win_last  = win_last_q;
  assign done      = done_q;
  assign cfg_err   = cfg_err_q;
  assign err_last  = err_last_q;
  assign busy      = (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_conv_window_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_conv_window_buffer
//  Purpose  : Self-checking bench for conv_window_buffer (K=3 and K=5 builds)
//             against a frame-level window model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_conv_window_buffer;

  localparam int DW = 16;
  localparam int KA = 3;
  localparam int KB = 5;
  localparam int WA = KA * KA * DW;
  localparam int WB = KB * KB * DW;

  typedef struct {
    logic [WA-1:0] data;
    bit            last;
  } win_t;

  logic clk = 1'b0;
  logic rst;

  // K=3 instance signals
  logic [10:0]   a_cfg_w, a_cfg_h;
  logic          a_cfg_start, a_cfg_err;
  logic          a_s_valid, a_s_ready, a_s_last;
  logic [DW-1:0] a_s_data;
  logic          a_win_valid, a_win_ready, a_win_last;
  logic [WA-1:0] a_win_data;
  logic          a_busy, a_done, a_err_last;

  // K=5 instance signals
  logic [10:0]   b_cfg_w, b_cfg_h;
  logic          b_cfg_start, b_cfg_err;
  logic          b_s_valid, b_s_ready, b_s_last;
  logic [DW-1:0] b_s_data;
  logic          b_win_valid, b_win_ready, b_win_last;
  logic [WB-1:0] b_win_data;
  logic          b_busy, b_done, b_err_last;

  int n_checks = 0;
  int n_fail   = 0;

  win_t          exp_q[$];
  logic [DW-1:0] pix [0:1023];
  int            rdy_mode  = 0;
  int            stall_cnt = 0;

  int            nb_win  = 0;
  int            nb_done = 0;
  logic [WB-1:0] b_cap;
  logic          b_cap_last;

  conv_window_buffer #(.DATA_W(DW), .KERNEL(KA), .MAX_WIDTH(32), .DIM_W(11)) dut_a (
    .Clk(clk), .Rst(rst),
    .cfg_width(a_cfg_w), .cfg_height(a_cfg_h), .cfg_start(a_cfg_start), .cfg_err(a_cfg_err),
    .s_axis_valid(a_s_valid), .s_axis_data(a_s_data), .s_axis_ready(a_s_ready), .s_axis_last(a_s_last),
    .win_valid(a_win_valid), .win_data(a_win_data), .win_ready(a_win_ready), .win_last(a_win_last),
    .busy(a_busy), .done(a_done), .err_last(a_err_last)
  );

  conv_window_buffer #(.DATA_W(DW), .KERNEL(KB), .MAX_WIDTH(16), .DIM_W(11)) dut_b (
    .Clk(clk), .Rst(rst),
    .cfg_width(b_cfg_w), .cfg_height(b_cfg_h), .cfg_start(b_cfg_start), .cfg_err(b_cfg_err),
    .s_axis_valid(b_s_valid), .s_axis_data(b_s_data), .s_axis_ready(b_s_ready), .s_axis_last(b_s_last),
    .win_valid(b_win_valid), .win_data(b_win_data), .win_ready(b_win_ready), .win_last(b_win_last),
    .busy(b_busy), .done(b_done), .err_last(b_err_last)
  );

  initial forever #5 clk = ~clk;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Model: every KAxKA window of the frame in pix[], in raster order of its
  // bottom-right pixel, slot r*K+c holding pixel (origin_row+r, origin_col+c).
  task automatic build_expected(input int w, input int h);
    win_t e;
    for (int r = KA - 1; r < h; r++) begin
      for (int c = KA - 1; c < w; c++) begin
        e.data = '0;
        for (int i = 0; i < KA; i++)
          for (int j = 0; j < KA; j++)
            e.data[(i*KA + j)*DW +: DW] = pix[(r - KA + 1 + i)*w + (c - KA + 1 + j)];
        e.last = (r == h - 1) && (c == w - 1);
        exp_q.push_back(e);
      end
    end
  endtask

  function automatic logic [WA-1:0] pack9(input int v [9]);
    logic [WA-1:0] d;
    d = '0;
    for (int i = 0; i < 9; i++) d[i*DW +: DW] = DW'(v[i]);
    return d;
  endfunction

  // Consumer-side ready pattern for the K=3 instance.
  initial begin
    a_win_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        1: a_win_ready = ($urandom_range(0, 3) != 0);
        2: if (a_win_valid && stall_cnt < 5) begin
             a_win_ready = 1'b0;
             stall_cnt++;
           end else begin
             a_win_ready = 1'b1;
           end
        default: a_win_ready = 1'b1;
      endcase
    end
  end

  // Compare process: every accepted window, done timing, stall behaviour.
  initial begin : cmp_a
    bit   done_due;
    win_t e;
    done_due = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        done_due = 0;
      end else begin
        check("done", a_done, done_due);
        done_due = 0;
        if (a_win_valid && a_win_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_window: got %0h, expected no window", a_win_data);
          end else begin
            e = exp_q.pop_front();
            check("win_data", a_win_data, e.data);
            check("win_last", a_win_last, e.last);
            done_due = e.last;
          end
        end
        if (a_win_valid && !a_win_ready) check("s_ready_while_stalled", a_s_ready, 0);
      end
    end
  end

  // Capture for the K=5 instance.
  initial begin : cap_b
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (b_win_valid && b_win_ready) begin
          nb_win++;
          b_cap      = b_win_data;
          b_cap_last = b_win_last;
        end
        if (b_done) nb_done++;
      end
    end
  end

  // pat: 0 = p=index, 1 = random. vmode: 0 = always valid, 1 = random gaps.
  task automatic run_frame(input int w, input int h, input int pat, input int vmode,
                           input int bad_last_idx, input bit drop_last,
                           input int stop_after, input bit poke_cfg);
    int i, cyc, n;
    bit hs;
    for (int k = 0; k < w*h; k++) pix[k] = pat ? DW'($urandom) : DW'(k);
    exp_q.delete();
    build_expected(w, h);
    a_cfg_w = 11'(w); a_cfg_h = 11'(h); a_cfg_start = 1'b1;
    @(posedge clk); #1;
    a_cfg_start = 1'b0;
    check("busy_after_start", a_busy, 1);
    check("cfg_err_after_start", a_cfg_err, 0);
    n   = (stop_after >= 0) ? stop_after : w*h;
    i   = 0;
    cyc = 0;
    while (i < n && cyc < 5000) begin
      a_s_valid = vmode ? ($urandom_range(0, 2) != 0) : 1'b1;
      a_s_data  = pix[i];
      a_s_last  = (i == bad_last_idx) || (i == w*h - 1 && !drop_last);
      if (poke_cfg && i == 3) begin
        a_cfg_w = 11'd1; a_cfg_start = 1'b1;
      end else begin
        a_cfg_start = 1'b0;
      end
      @(negedge clk);
      hs = a_s_valid && a_s_ready;
      @(posedge clk); #1;
      if (hs) i++;
      cyc++;
    end
    a_s_valid = 1'b0; a_s_last = 1'b0; a_cfg_start = 1'b0;
    check("pixels_accepted_in_time", (cyc < 5000), 1);
    if (stop_after < 0) begin
      cyc = 0;
      while (a_busy && cyc < 2000) begin
        @(posedge clk); #1;
        cyc++;
      end
      check("frame_completes", a_busy, 0);
      check("all_windows_seen", exp_q.size(), 0);
      check("err_last", a_err_last, (bad_last_idx >= 0) || drop_last);
      check("cfg_err_clear", a_cfg_err, 0);
    end
  endtask

  task automatic bad_cfg(input int w, input int h);
    a_cfg_w = 11'(w); a_cfg_h = 11'(h); a_cfg_start = 1'b1;
    @(posedge clk); #1;
    a_cfg_start = 1'b0;
    check("bad_cfg_err", a_cfg_err, 1);
    check("bad_cfg_busy", a_busy, 0);
    check("bad_cfg_ready", a_s_ready, 0);
  endtask

  initial begin : main
    int            v [9];
    logic [WB-1:0] exp5;
    int            cyc;
    bit            hs;
    int            k;

    rst = 1'b1;
    a_cfg_w = '0; a_cfg_h = '0; a_cfg_start = 1'b0;
    a_s_valid = 1'b0; a_s_data = '0; a_s_last = 1'b0;
    b_cfg_w = '0; b_cfg_h = '0; b_cfg_start = 1'b0;
    b_s_valid = 1'b0; b_s_data = '0; b_s_last = 1'b0; b_win_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Reset state
    check("rst_win_valid", a_win_valid, 0);
    check("rst_win_data", a_win_data, 0);
    check("rst_win_last", a_win_last, 0);
    check("rst_busy", a_busy, 0);
    check("rst_done", a_done, 0);
    check("rst_cfg_err", a_cfg_err, 0);
    check("rst_err_last", a_err_last, 0);
    check("rst_s_ready", a_s_ready, 0);
    check("rst_b_win_valid", b_win_valid, 0);

    // Pin the model against hand-computed windows.
    for (int i = 0; i < 9; i++) pix[i] = DW'(i);
    exp_q.delete(); build_expected(3, 3);
    v = '{0, 1, 2, 3, 4, 5, 6, 7, 8};
    check("model_3x3_count", exp_q.size(), 1);
    check("model_3x3_data", exp_q[0].data, pack9(v));
    check("model_3x3_last", exp_q[0].last, 1);
    for (int i = 0; i < 20; i++) pix[i] = DW'(i);
    exp_q.delete(); build_expected(5, 4);
    check("model_5x4_count", exp_q.size(), 6);
    v = '{0, 1, 2, 5, 6, 7, 10, 11, 12};
    check("model_5x4_first", exp_q[0].data, pack9(v));
    v = '{5, 6, 7, 10, 11, 12, 15, 16, 17};
    check("model_5x4_fourth", exp_q[3].data, pack9(v));
    check("model_5x4_last5", exp_q[4].last, 0);
    check("model_5x4_last6", exp_q[5].last, 1);
    exp_q.delete();

    // Directed frames; the 5x4 run pokes cfg_start mid-frame.
    rdy_mode = 0;
    run_frame(3, 3, 0, 0, -1, 0, -1, 0);
    run_frame(5, 4, 0, 0, -1, 0, -1, 1);
    rdy_mode = 2; stall_cnt = 0;
    run_frame(5, 4, 0, 0, -1, 0, -1, 0);
    check("stall_applied", stall_cnt, 5);
    rdy_mode = 0;

    // Illegal configurations, then a legal frame clears cfg_err.
    bad_cfg(2, 5);
    bad_cfg(33, 3);
    bad_cfg(3, 2);
    run_frame(3, 4, 1, 0, -1, 0, -1, 0);

    // tlast errors; the following clean frame must clear err_last.
    run_frame(4, 4, 0, 0, 5, 0, -1, 0);
    run_frame(4, 4, 0, 0, -1, 1, -1, 0);

    // Randomized frames including the maximum width.
    rdy_mode = 1;
    for (int f = 0; f < 6; f++)
      run_frame($urandom_range(3, 10), $urandom_range(3, 6), 1, 1, -1, 0, -1, 0);
    run_frame(32, 3, 1, 1, -1, 0, -1, 0);
    rdy_mode = 0;

    // Reset in the middle of a 4x4 frame after 7 pixels.
    run_frame(4, 4, 0, 0, -1, 0, 7, 0);
    #2 rst = 1'b1;
    #1;
    check("abort_win_valid", a_win_valid, 0);
    check("abort_win_data", a_win_data, 0);
    check("abort_win_last", a_win_last, 0);
    check("abort_busy", a_busy, 0);
    check("abort_done", a_done, 0);
    check("abort_cfg_err", a_cfg_err, 0);
    check("abort_err_last", a_err_last, 0);
    check("abort_s_ready", a_s_ready, 0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("abort_no_partial_window", a_win_valid, 0);
    check("abort_idle", a_busy, 0);

    // K=5 build, one 5x5 frame.
    b_cfg_w = 11'd5; b_cfg_h = 11'd5; b_cfg_start = 1'b1;
    @(posedge clk); #1;
    b_cfg_start = 1'b0;
    k = 0; cyc = 0;
    while (k < 25 && cyc < 500) begin
      b_s_valid = 1'b1; b_s_data = DW'(k); b_s_last = (k == 24);
      @(negedge clk);
      hs = b_s_valid && b_s_ready;
      @(posedge clk); #1;
      if (hs) k++;
      cyc++;
    end
    b_s_valid = 1'b0; b_s_last = 1'b0;
    cyc = 0;
    while (b_busy && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    repeat (2) @(posedge clk);
    #1;
    exp5 = '0;
    for (int i = 0; i < 25; i++) exp5[i*DW +: DW] = DW'(i);
    check("k5_window_count", nb_win, 1);
    check("k5_window_data", b_cap, exp5);
    check("k5_window_last", b_cap_last, 1);
    check("k5_done_pulses", nb_done, 1);
    check("k5_idle", b_busy, 0);
    check("k5_err_last", b_err_last, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
